hcp_cmd_responder: RTL and testbench
====================================

// Module: hcp_cmd_responder
// PURPOSE
//  Target-side end of the HCP command interface. Accepts 204b write/read commands from the hardware control point.
//  Queues them and executes each as a single-beat access on a local register bus.
//  Each read returns exactly one 204b ack word. Sits in the TSN NIC datapath next to the configurable tables/registers.
// PARAMETERS
//  FIFO_DEPTH  4    entries per command FIFO (wr and rd FIFOs separate); power of 2, >=2
//  DW          32   register data width; <=160
//  RD_TIMEOUT  255  max cycles in READ_WAIT before error ack; >=1
// PORTS
//  i_clk                clk  in   1     system clock
//  i_rst                in   1     reset: synchronous, active-high
//  iv_wr_command        in   204   write command word
//  i_wr_command_wr      in   1     iv_wr_command valid (1-cycle strobe)
//  iv_rd_command        in   204   read command word
//  i_rd_command_wr      in   1     iv_rd_command valid (1-cycle strobe)
//  ov_rd_command_ack    out  204   read ack word
//  o_rd_command_ack_wr  out  1     ack valid (1-cycle strobe)
//  ov_reg_blk           out  8     block id for current access
//  ov_reg_addr          out  32    register address
//  ov_reg_wdata         out  DW    write data
//  o_reg_wr             out  1     write strobe (1 cycle)
//  o_reg_rd             out  1     read strobe (1 cycle)
//  iv_reg_rdata         in   DW    read data, qualified by i_reg_rdata_valid
//  i_reg_rdata_valid    in   1     read data valid (1 cycle)
//  ov_wr_drop_cnt       out  16    wr commands dropped (FIFO full / bad type); saturates at 16'hFFFF
//  ov_rd_drop_cnt       out  16    rd commands dropped; saturates
//  ov_timeout_cnt       out  16    read timeouts; saturates
//  ov_rcs_state         out  3     FSM state, debug
// BEHAVIOUR
//  Command format: [203:200] type (4'h1 write, 4'h2 read), [199:192] block id, [191:160] addr, [159:0] data.
//  Only the low DW data bits are used.
//  Push: a strobe with the correct type (4'h1 on wr port, 4'h2 on rd port) pushes into that port's FIFO.
//  Drops: a strobe with the wrong type, or a push into a full FIFO, drops the command and increments that port's drop count.
//  FIFOs are show-ahead; data pushed at cycle T is visible at T+1. wr and rd strobes may coincide; both are accepted.
//  Arbitration in IDLE: wr FIFO non-empty has strict priority over rd FIFO. Cross-port ordering is not preserved.
//  FSM states (ov_rcs_state): IDLE=0, WRITE=1, READ_ISSUE=2, READ_WAIT=3, ACK=4.
//   IDLE: pop the selected FIFO head into a holding register. Go to WRITE or READ_ISSUE; stay in IDLE if both FIFOs are empty.
//   WRITE: o_reg_wr=1 for exactly 1 cycle with blk/addr/wdata held, then IDLE.
//   READ_ISSUE: o_reg_rd=1 for 1 cycle, clear the timeout counter, go to READ_WAIT.
//   READ_WAIT: counter increments each cycle.
//    i_reg_rdata_valid=1 latches iv_reg_rdata and goes to ACK(ok).
//    If the counter reaches RD_TIMEOUT with no valid, go to ACK(err) and increment ov_timeout_cnt.
//    If valid and the timeout coincide, valid wins (ok).
//   ACK: o_rd_command_ack_wr=1 for 1 cycle, then IDLE.
//    Ack word: [203:200]=4'h3 ok / 4'hE err; [199:160] copied from the request; [159:0]=zero-extended rdata (0 on err).
//  Latency: wr strobe at T -> o_reg_wr at T+2. rd strobe at T (idle, wr FIFO empty) -> o_reg_rd at T+2.
//  Read completion: rdata_valid at V -> ack at V+1. Back-to-back writes: one o_reg_wr every 2 cycles.
//  i_reg_rdata_valid outside READ_WAIT is ignored.
//  ov_reg_blk/addr/wdata hold the last access value between strobes.
//  Reset (any cycle, incl. mid-read): FIFOs flushed, FSM->IDLE, all counters 0, all outputs 0, no ack for the in-flight read.
//  A late rdata_valid after reset is ignored.
// TESTING
//  1 Write: wr cmd {4'h1,8'h05,32'h0000_0010,..,32'hDEAD_BEEF} @T -> o_reg_wr @T+2, blk 05, addr 10, wdata DEADBEEF; no ack.
//  2 Read: rd cmd {4'h2,8'h03,32'h20} @T, valid @T+5 rdata 32'h1234 -> ack @T+6 = {4'h3,8'h03,32'h20,160'h1234}.
//  3 Timeout: read with no valid -> after RD_TIMEOUT cycles in READ_WAIT, ack {4'hE,...,0}; ov_timeout_cnt=1.
//  4 Simultaneous wr+rd strobes @T -> o_reg_wr @T+2, o_reg_rd @T+4; both served, drop counts stay 0.
//  5 Overflow: FIFO_DEPTH+2 back-to-back wr strobes while FSM is blocked in READ_WAIT -> exactly 2 dropped; ov_wr_drop_cnt=2.
//    Then 1 wr strobe with type 4'h2 -> ov_wr_drop_cnt=3.
//  6 Reset asserted in READ_WAIT, then valid pulses -> no ack, state 0, FIFOs empty; next read completes normally.

Source files
------------

// File: rtl/hcp_cmd_responder_if.sv
// HCP command/ack and local register bus signals of the command responder.
// The slave modport is the responder's view; master is the controller/bus side.
interface hcp_cmd_responder_if #(
   parameter int unsigned DW = 32
);
   logic [203:0]  iv_wr_command;
   logic          i_wr_command_wr;
   logic [203:0]  iv_rd_command;
   logic          i_rd_command_wr;
   logic [203:0]  ov_rd_command_ack;
   logic          o_rd_command_ack_wr;
   logic [7:0]    ov_reg_blk;
   logic [31:0]   ov_reg_addr;
   logic [DW-1:0] ov_reg_wdata;
   logic          o_reg_wr;
   logic          o_reg_rd;
   logic [DW-1:0] iv_reg_rdata;
   logic          i_reg_rdata_valid;
   logic [15:0]   ov_wr_drop_cnt;
   logic [15:0]   ov_rd_drop_cnt;
   logic [15:0]   ov_timeout_cnt;
   logic [2:0]    ov_rcs_state;

   modport slave (
      input  iv_wr_command, i_wr_command_wr, iv_rd_command, i_rd_command_wr,
      input  iv_reg_rdata, i_reg_rdata_valid,
      output ov_rd_command_ack, o_rd_command_ack_wr,
      output ov_reg_blk, ov_reg_addr, ov_reg_wdata, o_reg_wr, o_reg_rd,
      output ov_wr_drop_cnt, ov_rd_drop_cnt, ov_timeout_cnt, ov_rcs_state
   );

   modport master (
      output iv_wr_command, i_wr_command_wr, iv_rd_command, i_rd_command_wr,
      output iv_reg_rdata, i_reg_rdata_valid,
      input  ov_rd_command_ack, o_rd_command_ack_wr,
      input  ov_reg_blk, ov_reg_addr, ov_reg_wdata, o_reg_wr, o_reg_rd,
      input  ov_wr_drop_cnt, ov_rd_drop_cnt, ov_timeout_cnt, ov_rcs_state
   );
endinterface

// File: rtl/hcp_cmd_responder.sv
// HCP command target: queues write/read commands in two FIFOs and runs each as a
// single-beat register-bus access; every read returns one ack word.
module hcp_cmd_responder #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DW         = 32,
   parameter int unsigned RD_TIMEOUT = 255
) (
   input logic                i_clk,
   input logic                i_rst,
   hcp_cmd_responder_if.slave bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
   localparam int unsigned WW = DW + 40;

   localparam logic [3:0] TypeWr     = 4'h1;
   localparam logic [3:0] TypeRd     = 4'h2;
   localparam logic [3:0] TypeAckOk  = 4'h3;
   localparam logic [3:0] TypeAckErr = 4'hE;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StWrite     = 3'd1,
      StReadIssue = 3'd2,
      StReadWait  = 3'd3,
      StAck       = 3'd4
   } state_e;

   state_e        state_q;
   logic [WW-1:0] wr_mem [FIFO_DEPTH];
   logic [39:0]   rd_mem [FIFO_DEPTH];
   logic [AW:0]   wr_wptr_q, wr_rptr_q, rd_wptr_q, rd_rptr_q;
   logic [15:0]   wr_drop_cnt_q, rd_drop_cnt_q, timeout_cnt_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    blk_q;
   logic [31:0]   addr_q;
   logic [DW-1:0] wdata_q;
   logic          reg_wr_q, reg_rd_q, ack_wr_q;
   logic [203:0]  ack_q;

   logic          wr_empty, wr_full, rd_empty, rd_full;
   logic          wr_push, wr_drop, rd_push, rd_drop, wr_pop, rd_pop;
   logic [WW-1:0] wr_head;
   logic [39:0]   rd_head;
   logic          unused_cmd_bits;

   // Data bits above DW on the write port and the whole read payload are never used.
   assign unused_cmd_bits = ^{bus.iv_wr_command[159:0], bus.iv_rd_command[159:0]};

   assign wr_empty = (wr_wptr_q == wr_rptr_q);
   assign rd_empty = (rd_wptr_q == rd_rptr_q);
   assign wr_full  = (wr_wptr_q[AW] != wr_rptr_q[AW]) &&
                     (wr_wptr_q[AW-1:0] == wr_rptr_q[AW-1:0]);
   assign rd_full  = (rd_wptr_q[AW] != rd_rptr_q[AW]) &&
                     (rd_wptr_q[AW-1:0] == rd_rptr_q[AW-1:0]);

   assign wr_push = bus.i_wr_command_wr && (bus.iv_wr_command[203:200] == TypeWr) && !wr_full;
   assign wr_drop = bus.i_wr_command_wr && !wr_push;
   assign rd_push = bus.i_rd_command_wr && (bus.iv_rd_command[203:200] == TypeRd) && !rd_full;
   assign rd_drop = bus.i_rd_command_wr && !rd_push;

   assign wr_pop  = (state_q == StIdle) && !wr_empty;
   assign rd_pop  = (state_q == StIdle) && wr_empty && !rd_empty;
   assign wr_head = wr_mem[wr_rptr_q[AW-1:0]];
   assign rd_head = rd_mem[rd_rptr_q[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (wr_push) begin
         wr_mem[wr_wptr_q[AW-1:0]] <= {bus.iv_wr_command[199:160], bus.iv_wr_command[DW-1:0]};
      end
      if (rd_push) begin
         rd_mem[rd_wptr_q[AW-1:0]] <= bus.iv_rd_command[199:160];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_wptr_q     <= '0;
         wr_rptr_q     <= '0;
         rd_wptr_q     <= '0;
         rd_rptr_q     <= '0;
         wr_drop_cnt_q <= '0;
         rd_drop_cnt_q <= '0;
      end else begin
         if (wr_push) wr_wptr_q <= wr_wptr_q + 1'b1;
         if (rd_push) rd_wptr_q <= rd_wptr_q + 1'b1;
         if (wr_pop)  wr_rptr_q <= wr_rptr_q + 1'b1;
         if (rd_pop)  rd_rptr_q <= rd_rptr_q + 1'b1;
         if (wr_drop && wr_drop_cnt_q != 16'hFFFF) wr_drop_cnt_q <= wr_drop_cnt_q + 16'd1;
         if (rd_drop && rd_drop_cnt_q != 16'hFFFF) rd_drop_cnt_q <= rd_drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= StIdle;
         blk_q         <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         reg_wr_q      <= 1'b0;
         reg_rd_q      <= 1'b0;
         ack_wr_q      <= 1'b0;
         ack_q         <= '0;
         tmo_q         <= '0;
         timeout_cnt_q <= '0;
      end else begin
         reg_wr_q <= 1'b0;
         reg_rd_q <= 1'b0;
         ack_wr_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (wr_pop) begin
                  blk_q    <= wr_head[WW-1:WW-8];
                  addr_q   <= wr_head[DW+31:DW];
                  wdata_q  <= wr_head[DW-1:0];
                  reg_wr_q <= 1'b1;
                  state_q  <= StWrite;
               end else if (rd_pop) begin
                  blk_q    <= rd_head[39:32];
                  addr_q   <= rd_head[31:0];
                  reg_rd_q <= 1'b1;
                  state_q  <= StReadIssue;
               end
            end
            StWrite: state_q <= StIdle;
            StReadIssue: begin
               tmo_q   <= '0;
               state_q <= StReadWait;
            end
            StReadWait: begin
               // Valid on the final wait cycle still completes the read successfully.
               if (bus.i_reg_rdata_valid) begin
                  ack_q    <= {TypeAckOk, blk_q, addr_q, 160'(bus.iv_reg_rdata)};
                  ack_wr_q <= 1'b1;
                  state_q  <= StAck;
               end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
                  ack_q    <= {TypeAckErr, blk_q, addr_q, 160'd0};
                  ack_wr_q <= 1'b1;
                  state_q  <= StAck;
                  if (timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StAck: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ov_rd_command_ack   = ack_q;
   assign bus.o_rd_command_ack_wr = ack_wr_q;
   assign bus.ov_reg_blk          = blk_q;
   assign bus.ov_reg_addr         = addr_q;
   assign bus.ov_reg_wdata        = wdata_q;
   assign bus.o_reg_wr            = reg_wr_q;
   assign bus.o_reg_rd            = reg_rd_q;
   assign bus.ov_wr_drop_cnt      = wr_drop_cnt_q;
   assign bus.ov_rd_drop_cnt      = rd_drop_cnt_q;
   assign bus.ov_timeout_cnt      = timeout_cnt_q;
   assign bus.ov_rcs_state        = state_q;
endmodule

// File: tb/tb_hcp_cmd_responder.sv
// Bench for hcp_cmd_responder: transaction-level model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hcp_cmd_responder;
   localparam int unsigned FD  = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 20;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   bit   chk_en;
   bit   rnd_valid;

   hcp_cmd_responder_if #(.DW(DW)) bus ();

   hcp_cmd_responder #(.FIFO_DEPTH(FD), .DW(DW), .RD_TIMEOUT(TMO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [203:0] act, input logic [203:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: queues of pending commands plus timestamps for when the engine frees up.
   logic [DW+39:0] wq[$];
   logic [39:0]    rq[$];
   int             cyc, free_at, wait_first;
   bit             reading;
   logic [39:0]    cur_req;
   bit             e_wr, e_rd, e_ack;
   logic [203:0]   e_ack_word;
   logic [7:0]     e_blk;
   logic [31:0]    e_addr;
   logic [DW-1:0]  e_wdata;
   int             e_wdrop, e_rdrop, e_tmo, e_state;

   initial begin
      cyc = 0; free_at = 0; reading = 0; wait_first = 0;
      e_wdrop = 0; e_rdrop = 0; e_tmo = 0; e_state = 0;
   end

   always @(posedge clk) begin
      logic [DW+39:0] w;
      bit             wfull, rfull;
      e_wr = 0; e_rd = 0; e_ack = 0;
      if (rst) begin
         wq.delete();
         rq.delete();
         reading = 0;
         free_at = cyc + 1;
         e_wdrop = 0; e_rdrop = 0; e_tmo = 0;
         e_state = 0;
      end else begin
         wfull = (wq.size() == FD);
         rfull = (rq.size() == FD);
         if (reading) begin
            if (cyc >= wait_first) begin
               if (bus.i_reg_rdata_valid) begin
                  e_ack = 1;
                  e_ack_word = {4'h3, cur_req, 160'(bus.iv_reg_rdata)};
               end else if (cyc == wait_first + TMO - 1) begin
                  e_ack = 1;
                  e_ack_word = {4'hE, cur_req, 160'd0};
                  if (e_tmo < 65535) e_tmo++;
               end
               if (e_ack) begin
                  reading = 0;
                  free_at = cyc + 2;
               end
            end
         end else if (cyc >= free_at) begin
            if (wq.size() > 0) begin
               w = wq.pop_front();
               e_wr = 1;
               e_blk = w[DW+39:DW+32];
               e_addr = w[DW+31:DW];
               e_wdata = w[DW-1:0];
               free_at = cyc + 2;
            end else if (rq.size() > 0) begin
               cur_req = rq.pop_front();
               e_rd = 1;
               e_blk = cur_req[39:32];
               e_addr = cur_req[31:0];
               reading = 1;
               wait_first = cyc + 2;
            end
         end
         if (bus.i_wr_command_wr) begin
            if (bus.iv_wr_command[203:200] == 4'h1 && !wfull)
               wq.push_back({bus.iv_wr_command[199:160], bus.iv_wr_command[DW-1:0]});
            else if (e_wdrop < 65535) e_wdrop++;
         end
         if (bus.i_rd_command_wr) begin
            if (bus.iv_rd_command[203:200] == 4'h2 && !rfull)
               rq.push_back(bus.iv_rd_command[199:160]);
            else if (e_rdrop < 65535) e_rdrop++;
         end
         if (e_wr) e_state = 1;
         else if (e_rd) e_state = 2;
         else if (e_ack) e_state = 4;
         else if (reading && cyc + 1 >= wait_first) e_state = 3;
         else e_state = 0;
      end
      cyc++;
      chk_en = 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("state", 204'(bus.ov_rcs_state), 204'(e_state));
         check("reg_wr", 204'(bus.o_reg_wr), 204'(e_wr));
         check("reg_rd", 204'(bus.o_reg_rd), 204'(e_rd));
         check("ack_wr", 204'(bus.o_rd_command_ack_wr), 204'(e_ack));
         check("wr_drop", 204'(bus.ov_wr_drop_cnt), 204'(e_wdrop));
         check("rd_drop", 204'(bus.ov_rd_drop_cnt), 204'(e_rdrop));
         check("tmo_cnt", 204'(bus.ov_timeout_cnt), 204'(e_tmo));
         if (e_wr || e_rd) begin
            check("blk", 204'(bus.ov_reg_blk), 204'(e_blk));
            check("addr", 204'(bus.ov_reg_addr), 204'(e_addr));
         end
         if (e_wr) check("wdata", 204'(bus.ov_reg_wdata), 204'(e_wdata));
         if (e_ack) check("ack_word", bus.ov_rd_command_ack, e_ack_word);
      end
   end

   function automatic logic [203:0] mk(input logic [3:0] t, input logic [7:0] b,
                                       input logic [31:0] a, input logic [159:0] d);
      return {t, b, a, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_wr_command_wr = 1'b0;
      bus.i_rd_command_wr = 1'b0;
      bus.i_reg_rdata_valid = rnd_valid ? ($urandom_range(7) == 0) : 1'b0;
      bus.iv_reg_rdata = DW'($urandom());
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_wr(input logic [203:0] c);
      bus.iv_wr_command = c;
      bus.i_wr_command_wr = 1'b1;
   endtask

   task automatic send_rd(input logic [203:0] c);
      bus.iv_rd_command = c;
      bus.i_rd_command_wr = 1'b1;
   endtask

   task automatic give_valid(input logic [DW-1:0] d);
      bus.iv_reg_rdata = d;
      bus.i_reg_rdata_valid = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0; chk_en = 0; rnd_valid = 0;
      rst = 1'b1;
      bus.iv_wr_command = '0; bus.i_wr_command_wr = 1'b0;
      bus.iv_rd_command = '0; bus.i_rd_command_wr = 1'b0;
      bus.iv_reg_rdata = '0; bus.i_reg_rdata_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_state", 204'(bus.ov_rcs_state), 204'(0));
      check("rst_ack", bus.ov_rd_command_ack, 204'(0));
      check("rst_blk", 204'(bus.ov_reg_blk), 204'(0));
      check("rst_wdata", 204'(bus.ov_reg_wdata), 204'(0));

      // Single write: strobe at T, access at T+2, no ack.
      send_wr(mk(4'h1, 8'h05, 32'h0000_0010, 160'hDEAD_BEEF));
      steps(2);
      check("t1_reg_wr", 204'(bus.o_reg_wr), 204'(1));
      check("t1_blk", 204'(bus.ov_reg_blk), 204'(8'h05));
      check("t1_addr", 204'(bus.ov_reg_addr), 204'(32'h10));
      check("t1_wdata", 204'(bus.ov_reg_wdata), 204'(32'hDEAD_BEEF));
      check("t1_no_ack", 204'(bus.o_rd_command_ack_wr), 204'(0));
      steps(4);

      // Read answered at T+5, ack at T+6.
      send_rd(mk(4'h2, 8'h03, 32'h20, 160'h0));
      steps(2);
      check("t2_reg_rd", 204'(bus.o_reg_rd), 204'(1));
      steps(3);
      give_valid(32'h1234);
      step();
      check("t2_ack_wr", 204'(bus.o_rd_command_ack_wr), 204'(1));
      check("t2_ack", bus.ov_rd_command_ack, mk(4'h3, 8'h03, 32'h20, 160'h1234));
      steps(4);

      // Timeout: waiting starts at T+3, error ack TMO cycles later.
      send_rd(mk(4'h2, 8'h0A, 32'h44, 160'h5));
      steps(2 + TMO);
      check("t3_no_ack_yet", 204'(bus.o_rd_command_ack_wr), 204'(0));
      step();
      check("t3_ack_wr", 204'(bus.o_rd_command_ack_wr), 204'(1));
      check("t3_ack", bus.ov_rd_command_ack, mk(4'hE, 8'h0A, 32'h44, 160'h0));
      check("t3_tmo_cnt", 204'(bus.ov_timeout_cnt), 204'(1));
      steps(4);

      // Simultaneous strobes: write first, read two cycles later.
      send_wr(mk(4'h1, 8'h11, 32'h100, 160'hCAFE));
      send_rd(mk(4'h2, 8'h22, 32'h200, 160'h0));
      steps(2);
      check("t4_reg_wr", 204'(bus.o_reg_wr), 204'(1));
      steps(2);
      check("t4_reg_rd", 204'(bus.o_reg_rd), 204'(1));
      steps(2);
      give_valid(32'h77);
      step();
      check("t4_ack", bus.ov_rd_command_ack, mk(4'h3, 8'h22, 32'h200, 160'h77));
      check("t4_wr_drop", 204'(bus.ov_wr_drop_cnt), 204'(0));
      check("t4_rd_drop", 204'(bus.ov_rd_drop_cnt), 204'(0));
      steps(4);

      // Overflow while the engine is parked waiting on a read.
      send_rd(mk(4'h2, 8'h33, 32'h300, 160'h0));
      steps(3);
      for (int i = 0; i < FD + 2; i++) begin
         send_wr(mk(4'h1, 8'h40 + 8'(i), 32'h400 + 32'(i), 160'(i)));
         step();
      end
      check("t5_drop2", 204'(bus.ov_wr_drop_cnt), 204'(2));
      send_wr(mk(4'h2, 8'h50, 32'h500, 160'h0));
      step();
      check("t5_drop3", 204'(bus.ov_wr_drop_cnt), 204'(3));
      steps(TMO + 2 * FD + 4);
      check("t5_tmo_cnt", 204'(bus.ov_timeout_cnt), 204'(2));

      // Reset in the middle of a read; late valids must not produce an ack.
      send_rd(mk(4'h2, 8'h66, 32'h600, 160'h0));
      steps(5);
      rst = 1'b1;
      step();
      check("t6_state", 204'(bus.ov_rcs_state), 204'(0));
      check("t6_tmo_cnt", 204'(bus.ov_timeout_cnt), 204'(0));
      check("t6_wr_drop", 204'(bus.ov_wr_drop_cnt), 204'(0));
      for (int i = 0; i < 3; i++) begin
         give_valid(32'hBAD0 + 32'(i));
         step();
         check("t6_no_ack", 204'(bus.o_rd_command_ack_wr), 204'(0));
      end
      send_rd(mk(4'h2, 8'h07, 32'h30, 160'h0));
      steps(4);
      give_valid(32'h55);
      step();
      check("t6_ack", bus.ov_rd_command_ack, mk(4'h3, 8'h07, 32'h30, 160'h55));
      steps(3);

      // Random traffic against the model.
      rnd_valid = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) begin
            send_wr(mk(($urandom_range(7) == 0) ? 4'(2 + $urandom_range(5)) : 4'h1,
                       8'($urandom()), $urandom(),
                       {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}));
         end
         if ($urandom_range(4) == 0) begin
            send_rd(mk(($urandom_range(7) == 0) ? 4'h1 : 4'h2, 8'($urandom()), $urandom(),
                       160'($urandom())));
         end
         if ($urandom_range(700) == 0) rst = 1'b1;
         step();
      end
      rnd_valid = 0;
      steps(TMO + 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
